// File: rtl/mbist_pkg.sv
// Shared definitions for the March C- MBIST controller.
//  - state_e : controller FSM states (also exposed on the top's debug port)
//  - elem_e  : March C- elements M0..M5
//  - OP_WRITE / OP_READ : values driven on write_read_mbist
//  - per-element tables: address direction, op count, op type,
//    expected read background and write background
package mbist_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_OP,
    ST_WAIT,
    ST_CMP,
    ST_DONE
  } state_e;

  typedef enum logic [2:0] {
    M0, M1, M2, M3, M4, M5
  } elem_e;

  localparam logic OP_WRITE = 1'b1;
  localparam logic OP_READ  = 1'b0;

  // M3 and M4 walk the address space downward, all others upward.
  function automatic logic elem_down(elem_e e);
    return (e == M3) || (e == M4);
  endfunction

  // M1..M4 are read-then-write; M0 (w0) and M5 (r0) have a single op.
  function automatic logic elem_two_ops(elem_e e);
    return (e != M0) && (e != M5);
  endfunction

  // Op index 0 is a read in every element except M0; index 1 is always a write.
  function automatic logic op_type(elem_e e, logic idx);
    return ((e != M0) && !idx) ? OP_READ : OP_WRITE;
  endfunction

  // Background expected by the read of each element (0 = all 0s, 1 = all 1s).
  function automatic logic read_bg(elem_e e);
    return (e == M2) || (e == M4);
  endfunction

  // Background written by the write of each element.
  function automatic logic write_bg(elem_e e);
    return (e == M1) || (e == M3);
  endfunction

endpackage

// File: rtl/mbist_addr_gen.sv
// Loadable up/down word-address counter for one memory of MEM_DEPTH words.
//  clk, rst  : clock, synchronous active-high reset (addr -> 0)
//  clear     : force addr to 0 (run start / run end)
//  load      : load the first address of a walk: 0 when up, MEM_DEPTH-1 when down
//  step      : move one address in the direction given by down
//  down      : direction for load/step
//  addr      : current address (registered)
//  is_first  : addr == 0
//  is_last   : addr == MEM_DEPTH-1
module mbist_addr_gen #(
  parameter int ADDR_WIDTH = 16,
  parameter int MEM_DEPTH  = 2 ** ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clear,
  input  logic                  load,
  input  logic                  step,
  input  logic                  down,
  output logic [ADDR_WIDTH-1:0] addr,
  output logic                  is_first,
  output logic                  is_last
);

  localparam logic [ADDR_WIDTH-1:0] TOP = ADDR_WIDTH'(MEM_DEPTH - 1);

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      addr <= '0;
    end else if (load) begin
      addr <= down ? TOP : '0;
    end else if (step) begin
      addr <= down ? addr - 1'b1 : addr + 1'b1;
    end
  end

  assign is_first = (addr == '0);
  assign is_last  = (addr == TOP);

endmodule

// File: rtl/mbist_march_ctrl.sv
// March C- MBIST initiator. Tests memories 0..NUM_MEM-1 in turn through the
// memory-select mux, compares read data against the expected background and
// records the first failure plus a saturating failure count.
//  clk, rst          : clock, synchronous active-high reset (aborts a run)
//  start             : one-cycle pulse, accepted only when not busy
//  memory_sel        : memory under test
//  write_read_mbist  : 1 = write, 0 = read
//  address_mbist     : word address
//  wdata_mbist       : write data (0 while reading)
//  rdata_mbist       : read data, valid RD_LATENCY edges after a read is presented
//  busy / done       : run in progress / run finished (held until next start)
//  fail, fail_mem, fail_addr, fail_element, fail_count : run result
//  state             : FSM state, for debug
//
// Handshake: start is sampled on a rising edge while idle or done; busy rises on
// that edge and stays high for the whole run; on the edge that completes the last
// compare busy falls and done rises, staying high until the next accepted start.
module mbist_march_ctrl
  import mbist_pkg::*;
#(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 16,
  parameter int MEM_DEPTH  = 2 ** ADDR_WIDTH,
  parameter int NUM_MEM    = 4,
  parameter int RD_LATENCY = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  output logic [2:0]            memory_sel,
  output logic                  write_read_mbist,
  output logic [ADDR_WIDTH-1:0] address_mbist,
  output logic [DATA_WIDTH-1:0] wdata_mbist,
  input  logic [DATA_WIDTH-1:0] rdata_mbist,
  output logic                  busy,
  output logic                  done,
  output logic                  fail,
  output logic [2:0]            fail_mem,
  output logic [ADDR_WIDTH-1:0] fail_addr,
  output logic [2:0]            fail_element,
  output logic [15:0]           fail_count,
  output state_e                state
);

  localparam int         WAIT_CYC = RD_LATENCY - 1;
  localparam int         LAT_W    = (RD_LATENCY > 1) ? $clog2(RD_LATENCY) : 1;
  localparam logic [2:0] MEM_LAST = 3'(NUM_MEM - 1);

  elem_e            elem;
  logic             op_idx;
  logic [LAT_W-1:0] lat_cnt;

  logic  addr_first, addr_last;
  logic  start_ok, advance;
  logic  addr_clear, addr_load, addr_step, addr_down;
  logic  dec_load, dec_step, run_end, nxt_idx;
  elem_e nxt_elem;
  logic [2:0] nxt_mem;
  logic  mismatch;

  mbist_addr_gen #(
    .ADDR_WIDTH(ADDR_WIDTH),
    .MEM_DEPTH (MEM_DEPTH)
  ) u_addr_gen (
    .clk     (clk),
    .rst     (rst),
    .clear   (addr_clear),
    .load    (addr_load),
    .step    (addr_step),
    .down    (addr_down),
    .addr    (address_mbist),
    .is_first(addr_first),
    .is_last (addr_last)
  );

  // Next-op decode: second op at this address, else next address, else next
  // element, else next memory, else end of run.
  always_comb begin
    nxt_idx  = 1'b0;
    nxt_elem = elem;
    nxt_mem  = memory_sel;
    dec_load = 1'b0;
    dec_step = 1'b0;
    run_end  = 1'b0;
    if (elem_two_ops(elem) && !op_idx) begin
      nxt_idx = 1'b1;
    end else if (!(elem_down(elem) ? addr_first : addr_last)) begin
      dec_step = 1'b1;
    end else if (elem != M5) begin
      nxt_elem = elem_e'(elem + 3'd1);
      dec_load = 1'b1;
    end else if (memory_sel != MEM_LAST) begin
      nxt_mem  = memory_sel + 3'd1;
      nxt_elem = M0;
      dec_load = 1'b1;
    end else begin
      run_end = 1'b1;
    end
  end

  // A write completes in its single OP cycle; a read completes in its CMP cycle.
  assign start_ok   = ((state == ST_IDLE) || (state == ST_DONE)) && start;
  assign advance    = ((state == ST_OP) && (op_type(elem, op_idx) == OP_WRITE)) ||
                      (state == ST_CMP);
  assign addr_clear = start_ok || (advance && run_end);
  assign addr_load  = advance && dec_load;
  assign addr_step  = advance && dec_step;
  // A load starts the walk of the element being entered; a step continues the current one.
  assign addr_down  = dec_load ? elem_down(nxt_elem) : elem_down(elem);
  assign mismatch   = (rdata_mbist != {DATA_WIDTH{read_bg(elem)}});

  always_ff @(posedge clk) begin
    if (rst) begin
      state            <= ST_IDLE;
      elem             <= M0;
      op_idx           <= 1'b0;
      lat_cnt          <= '0;
      memory_sel       <= '0;
      write_read_mbist <= 1'b0;
      wdata_mbist      <= '0;
      busy             <= 1'b0;
      done             <= 1'b0;
      fail             <= 1'b0;
      fail_mem         <= '0;
      fail_addr        <= '0;
      fail_element     <= '0;
      fail_count       <= '0;
    end else begin
      unique case (state)
        ST_IDLE, ST_DONE: begin
          state <= ST_IDLE;
          if (start_ok) begin
            state            <= ST_OP;
            busy             <= 1'b1;
            done             <= 1'b0;
            fail             <= 1'b0;
            fail_mem         <= '0;
            fail_addr        <= '0;
            fail_element     <= '0;
            fail_count       <= '0;
            memory_sel       <= '0;
            elem             <= M0;
            op_idx           <= 1'b0;
            write_read_mbist <= op_type(M0, 1'b0);
            wdata_mbist      <= {DATA_WIDTH{write_bg(M0)}};
          end
        end
        ST_OP: begin
          // Reads hold sel/addr with write_read_mbist already 0 until the compare.
          if (op_type(elem, op_idx) == OP_READ) begin
            if (WAIT_CYC == 0) begin
              state <= ST_CMP;
            end else begin
              state   <= ST_WAIT;
              lat_cnt <= LAT_W'(1);
            end
          end
        end
        ST_WAIT: begin
          if (lat_cnt == LAT_W'(WAIT_CYC)) begin
            state <= ST_CMP;
          end else begin
            lat_cnt <= lat_cnt + 1'b1;
          end
        end
        ST_CMP: begin
          if (mismatch) begin
            fail <= 1'b1;
            if (fail_count != 16'hFFFF) fail_count <= fail_count + 16'd1;
            if (!fail) begin
              fail_mem     <= memory_sel;
              fail_addr    <= address_mbist;
              fail_element <= elem;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase

      // Present the following op on the same edge that completes the current one.
      if (advance) begin
        if (run_end) begin
          state            <= ST_DONE;
          busy             <= 1'b0;
          done             <= 1'b1;
          memory_sel       <= '0;
          write_read_mbist <= 1'b0;
          wdata_mbist      <= '0;
          elem             <= M0;
          op_idx           <= 1'b0;
        end else begin
          state            <= ST_OP;
          memory_sel       <= nxt_mem;
          elem             <= nxt_elem;
          op_idx           <= nxt_idx;
          write_read_mbist <= op_type(nxt_elem, nxt_idx);
          wdata_mbist      <= (op_type(nxt_elem, nxt_idx) == OP_WRITE) ?
                              {DATA_WIDTH{write_bg(nxt_elem)}} : '0;
        end
      end
    end
  end

endmodule

// File: tb/tb_mbist_march_ctrl.sv
// Bench for mbist_march_ctrl: 4 memories of 16 x 64 bits behind a registered
// mux and a 1-cycle RAM (3-edge read latency), with one optional stuck-at bit.
// Each run is checked cycle by cycle against a trace and result built from the
// March C- algorithm walked directly over a behavioural memory.
module tb_mbist_march_ctrl;
  import mbist_pkg::*;

  localparam int DW = 64;
  localparam int AW = 4;
  localparam int DEPTH = 16;
  localparam int NMEM = 4;
  localparam int LAT = 3;
  localparam int VW = 2 + 3 + 1 + AW + DW;

  logic clk = 1'b0;
  logic rst, start;
  logic [2:0] memory_sel;
  logic write_read_mbist;
  logic [AW-1:0] address_mbist;
  logic [DW-1:0] wdata_mbist, rdata_mbist;
  logic busy, done, fail;
  logic [2:0] fail_mem, fail_element;
  logic [AW-1:0] fail_addr;
  logic [15:0] fail_count;
  state_e dut_state;

  mbist_march_ctrl #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MEM_DEPTH(DEPTH), .NUM_MEM(NMEM), .RD_LATENCY(LAT)
  ) dut (
    .clk(clk), .rst(rst), .start(start),
    .memory_sel(memory_sel), .write_read_mbist(write_read_mbist),
    .address_mbist(address_mbist), .wdata_mbist(wdata_mbist), .rdata_mbist(rdata_mbist),
    .busy(busy), .done(done), .fail(fail), .fail_mem(fail_mem), .fail_addr(fail_addr),
    .fail_element(fail_element), .fail_count(fail_count), .state(dut_state)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- fault definition ----------------
  bit fault_en;
  int fault_mem, fault_addr, fault_bit;
  bit fault_val;

  function automatic logic [DW-1:0] apply_fault(logic [DW-1:0] v, int m, int a);
    logic [DW-1:0] r;
    r = v;
    if (fault_en && m == fault_mem && a == fault_addr) r[fault_bit] = fault_val;
    return r;
  endfunction

  // ---------------- memory subsystem model ----------------
  logic [DW-1:0] ram [8][DEPTH];
  logic [2:0] p_sel;
  logic p_wr;
  logic [AW-1:0] p_addr;
  logic [DW-1:0] p_wdata, ram_q;

  always @(posedge clk) begin
    p_sel   <= memory_sel;
    p_wr    <= write_read_mbist;
    p_addr  <= address_mbist;
    p_wdata <= wdata_mbist;
    if (p_wr) ram[p_sel][p_addr] <= p_wdata;
    ram_q       <= apply_fault(ram[p_sel][p_addr], int'(p_sel), int'(p_addr));
    rdata_mbist <= ram_q;
  end

  // ---------------- scoreboard ----------------
  int vectors = 0;
  int miscompares = 0;
  logic [VW-1:0] exp_q[$];
  bit exp_fail;
  int exp_fmem, exp_faddr, exp_felem, exp_fcount;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // March C- as data: ops per element, read flag and background of each op.
  int op_n [6] = '{1, 2, 2, 2, 2, 1};
  bit op_rd [6][2] = '{'{0, 0}, '{1, 0}, '{1, 0}, '{1, 0}, '{1, 0}, '{1, 0}};
  bit op_val[6][2] = '{'{0, 0}, '{0, 1}, '{1, 0}, '{0, 1}, '{1, 0}, '{0, 0}};

  // Walk the algorithm over a plain array: per-cycle output trace plus result.
  task automatic build_expected();
    logic [DW-1:0] mm [NMEM][DEPTH];
    logic [DW-1:0] got;
    int a;
    exp_q.delete();
    exp_fail = 0; exp_fmem = 0; exp_faddr = 0; exp_felem = 0; exp_fcount = 0;
    for (int m = 0; m < NMEM; m++)
      for (int e = 0; e < 6; e++)
        for (int k = 0; k < DEPTH; k++) begin
          a = (e == 3 || e == 4) ? DEPTH - 1 - k : k;
          for (int o = 0; o < op_n[e]; o++) begin
            if (!op_rd[e][o]) begin
              exp_q.push_back({1'b1, 1'b0, 3'(m), 1'b1, AW'(a), {DW{op_val[e][o]}}});
              mm[m][a] = {DW{op_val[e][o]}};
            end else begin
              for (int c = 0; c <= LAT; c++)
                exp_q.push_back({1'b1, 1'b0, 3'(m), 1'b0, AW'(a), {DW{1'b0}}});
              got = apply_fault(mm[m][a], m, a);
              if (got !== {DW{op_val[e][o]}}) begin
                if (!exp_fail) begin
                  exp_fmem = m; exp_faddr = a; exp_felem = e;
                end
                exp_fail = 1;
                exp_fcount++;
              end
            end
          end
        end
  endtask

  function automatic logic [VW-1:0] observed();
    return {busy, done, memory_sel, write_read_mbist, address_mbist,
            write_read_mbist ? wdata_mbist : {DW{1'b0}}};
  endfunction

  // ---------------- driver ----------------
  // Starts a run from a negedge and checks every busy cycle. abort_at >= 0
  // asserts rst at that cycle instead of completing; noise adds random start
  // pulses while busy.
  task automatic run_test(input string name, input int abort_at, input bit noise);
    logic [VW-1:0] exp;
    int idx;
    build_expected();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check({name, "_cleared"}, {fail, fail_mem, fail_addr, fail_element, fail_count},
          '0);
    idx = 0;
    while (exp_q.size() > 0) begin
      if (idx == abort_at) begin
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check({name, "_abort_outs"}, {observed(), wdata_mbist}, '0);
        check({name, "_abort_fail"}, {fail, fail_mem, fail_addr, fail_element, fail_count},
              '0);
        return;
      end
      exp = exp_q.pop_front();
      check($sformatf("%s_cyc%0d", name, idx), observed(), exp);
      start = (noise && exp_q.size() > 0 && $urandom_range(0, 99) < 3) ? 1'b1 : 1'b0;
      @(negedge clk);
      idx++;
    end
    start = 1'b0;
    check({name, "_done_outs"}, {observed(), wdata_mbist},
          {2'b01, 3'd0, 1'b0, {AW{1'b0}}, {DW{1'b0}}, {DW{1'b0}}});
    check({name, "_result"}, {fail, fail_mem, fail_addr, fail_element, fail_count},
          {exp_fail, 3'(exp_fmem), AW'(exp_faddr), 3'(exp_felem), 16'(exp_fcount)});
    repeat ($urandom_range(1, 4)) @(negedge clk);
    check({name, "_done_held"}, {busy, done}, 2'b01);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b1; start = 1'b0; fault_en = 0;
    fault_mem = 0; fault_addr = 0; fault_bit = 0; fault_val = 0;
    for (int m = 0; m < 8; m++)
      for (int a = 0; a < DEPTH; a++) ram[m][a] = {$urandom, $urandom};
    repeat (3) @(negedge clk);
    check("reset_outs", {observed(), wdata_mbist}, '0);
    check("reset_fail", {fail, fail_mem, fail_addr, fail_element, fail_count}, '0);
    rst = 1'b0;
    @(negedge clk);

    // rst and start together: rst wins
    rst = 1'b1; start = 1'b1;
    @(negedge clk);
    rst = 1'b0; start = 1'b0;
    check("rst_wins", {busy, done}, 2'b00);
    @(negedge clk);

    // fault-free, with stray start pulses while busy
    run_test("clean", -1, 1'b1);
    check("clean_spec", {fail, fail_count}, {1'b0, 16'd0});

    // mem1 addr5 bit0 stuck-at-1
    fault_en = 1; fault_mem = 1; fault_addr = 5; fault_bit = 0; fault_val = 1;
    run_test("sa1", -1, 1'b0);
    check("sa1_spec", {fail, fail_mem, fail_addr, fail_element, fail_count},
          {1'b1, 3'd1, 4'd5, 3'd1, 16'd3});

    // mem3 addr15 bit63 stuck-at-0, then the same run again after done
    fault_mem = 3; fault_addr = 15; fault_bit = 63; fault_val = 0;
    run_test("sa0", -1, 1'b0);
    check("sa0_spec", {fail, fail_mem, fail_addr, fail_element, fail_count},
          {1'b1, 3'd3, 4'd15, 3'd2, 16'd2});
    run_test("sa0_again", -1, 1'b1);
    check("sa0_again_spec", {fail, fail_mem, fail_addr, fail_element, fail_count},
          {1'b1, 3'd3, 4'd15, 3'd2, 16'd2});

    // reset partway into M2 of memory 2, then a full restart
    fault_en = 0;
    run_test("abort", 2 * 400 + 112 + $urandom_range(0, 40), 1'b0);
    @(negedge clk);
    run_test("restart", -1, 1'b0);

    // random single stuck-at faults
    for (int r = 0; r < 3; r++) begin
      fault_en = 1;
      fault_mem = $urandom_range(0, NMEM - 1);
      fault_addr = $urandom_range(0, DEPTH - 1);
      fault_bit = $urandom_range(0, DW - 1);
      fault_val = 1'($urandom_range(0, 1));
      run_test($sformatf("rand%0d", r), -1, 1'b1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
